// File: rtl/dbg_scan.sv
// dbg_scan: walks a debug read-mux over an inclusive, wrapping address range
// and streams each captured word out over a valid/ready handshake.
// Ports:
//   clk, rst                      clock, async active-high reset
//   start, abort                  begin a scan (IDLE only) / cancel a scan
//   start_addr, end_addr          inclusive 7-bit range, latched on start
//   debug_addr, debug_data        read-mux address out, mux result in
//   out_valid, out_ready          output handshake
//   out_addr, out_data, out_last  captured word, its address, final-word flag
//   busy, done                    not-IDLE flag, one-clock completion pulse
module dbg_scan #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [6:0]  start_addr,
    input  logic [6:0]  end_addr,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SEND,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [6:0] end_lat;
    logic       settled;
    logic       hs;

    assign settled   = (cnt == 4'(SETTLE_CYCLES));
    assign hs        = out_valid & out_ready;
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = SETTLE;
            end
            SETTLE: begin
                if (abort)
                    state_nx = IDLE;
                else if (settled)
                    state_nx = SEND;
            end
            SEND: begin
                if (abort)
                    state_nx = IDLE;
                else if (hs)
                    state_nx = out_last ? DONE : SETTLE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The counter starts at 0 after start but at 1 after a handshake: the
    // first word gets one extra clock (range load), later words are spaced
    // SETTLE_CYCLES+1 clocks apart including the handshake clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            end_lat    <= '0;
            debug_addr <= '0;
            out_addr   <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        end_lat    <= end_addr;
                        debug_addr <= start_addr;
                        cnt        <= '0;
                    end
                end
                SETTLE: begin
                    if (!abort) begin
                        if (settled) begin
                            out_data <= debug_data;
                            out_addr <= debug_addr;
                            out_last <= (debug_addr == end_lat);
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                SEND: begin
                    if (!abort && hs && !out_last) begin
                        debug_addr <= debug_addr + 7'd1;
                        cnt        <= 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_scan.sv
// tb_dbg_scan: table-driven scans against a model read-mux, plus hand-written
// abort and mid-scan reset sequences.
module tb_dbg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [6:0]  start_addr;
    logic [6:0]  end_addr;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mux_f(input logic [6:0] a);
        logic [7:0] b;
        b = {1'b0, a};
        return {b, 8'h5A, ~b, 8'(b * 8'd3)};
    endfunction

    assign debug_data = mux_f(debug_addr);

    dbg_scan #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr),
        .debug_addr(debug_addr), .debug_data(debug_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0] s;
        logic [6:0] e;
        int         n;
        int         stall;
        bit         glitch;
    } vec_t;

    vec_t vecs[6];

    task automatic run_scan(input vec_t v);
        int         idx = 0;
        int         ndone = 0;
        int         first_i = -1;
        int         prev_i = -1;
        int         stall_n = 0;
        bit         fin = 0;
        logic [6:0] sa, sd;
        logic [31:0] sdat;
        logic       sl;
        logic [6:0] ea;
        @(negedge clk);
        start = 1; start_addr = v.s; end_addr = v.e; out_ready = 1;
        @(negedge clk);
        start = 0;
        for (int i = 1; i < 700 && !fin; i++) begin
            if (v.glitch && i == 4) begin
                start = 1; start_addr = 7'h60; end_addr = 7'h61;
            end
            if (v.glitch && i == 5) start = 0;
            if (done) begin
                ndone++;
                fin = 1;
            end else if (out_valid) begin
                if (idx == v.stall && stall_n < 5) begin
                    if (stall_n == 0) begin
                        sa = out_addr; sdat = out_data;
                        sl = out_last; sd = debug_addr;
                    end else begin
                        chk("stall_addr", 32'(out_addr), 32'(sa));
                        chk("stall_data", out_data, sdat);
                        chk("stall_last", 32'(out_last), 32'(sl));
                        chk("stall_dbg", 32'(debug_addr), 32'(sd));
                    end
                    out_ready = 0;
                    stall_n++;
                end else begin
                    out_ready = 1;
                    ea = v.s + 7'(idx);
                    if (first_i < 0) begin
                        first_i = i;
                        chk("latency", 32'(i - 1), 32'd2);
                    end
                    if (v.stall < 0 && prev_i >= 0)
                        chk("spacing", 32'(i - prev_i), 32'd2);
                    prev_i = i;
                    chk("word_addr", 32'(out_addr), 32'(ea));
                    chk("word_data", out_data, mux_f(ea));
                    chk("word_last", 32'(out_last),
                        32'(idx == v.n - 1));
                    idx++;
                end
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) chk("timeout", 32'd1, 32'd0);
        chk("word_count", 32'(idx), 32'(v.n));
        chk("done_count", 32'(ndone), 32'd1);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_dbg", 32'(debug_addr), 32'(v.e));
    endtask

    initial begin
        int nv;
        int seen;
        vecs[0] = '{s: 7'h40, e: 7'h47, n: 8,   stall: -1, glitch: 0};
        vecs[1] = '{s: 7'h7E, e: 7'h01, n: 4,   stall: -1, glitch: 0};
        vecs[2] = '{s: 7'h20, e: 7'h20, n: 1,   stall: -1, glitch: 0};
        vecs[3] = '{s: 7'h10, e: 7'h14, n: 5,   stall: 2,  glitch: 0};
        vecs[4] = '{s: 7'h05, e: 7'h0A, n: 6,   stall: -1, glitch: 1};
        vecs[5] = '{s: 7'h01, e: 7'h00, n: 128, stall: -1, glitch: 0};

        rst = 1; start = 0; abort = 0; out_ready = 1;
        start_addr = 7'h55; end_addr = 7'h2A;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbg", 32'(debug_addr), 32'd0);
        chk("rst_odata", out_data, 32'd0);
        rst = 0;
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("idle_abort_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 6; k++) run_scan(vecs[k]);

        // abort during SEND of word 2
        @(negedge clk);
        start = 1; start_addr = 7'h30; end_addr = 7'h38;
        @(negedge clk);
        start = 0;
        nv = 0;
        for (int i = 0; i < 50 && nv < 2; i++) begin
            if (out_valid) nv++;
            if (nv == 2) abort = 1;
            else @(negedge clk);
        end
        chk("abort_reached", 32'(nv), 32'd2);
        @(negedge clk);
        abort = 0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dbg", 32'(debug_addr), 32'h31);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // reset during SETTLE of a new scan
        start = 1; start_addr = 7'h50; end_addr = 7'h55;
        @(negedge clk);
        start = 0;
        chk("rst2_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1;
        #1;
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_dbg", 32'(debug_addr), 32'd0);
        chk("rst2_oaddr", 32'(out_addr), 32'd0);
        chk("rst2_odata", out_data, 32'd0);
        chk("rst2_olast", 32'(out_last), 32'd0);
        chk("rst2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || out_valid || busy) seen++;
            @(negedge clk);
        end
        chk("rst2_quiet", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_scan.md
DBG_SCAN -- requirements
Module: dbg_scan

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the clocks debug_addr is held before debug_data is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a scan, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1, which terminates a scan in progress.
REQ-006 The block SHALL have port start_addr, input, 7, the first debug address, latched on start.
REQ-007 The block SHALL have port end_addr, input, 7, the last debug address (inclusive), latched on start.
REQ-008 The block SHALL have port debug_addr, output, 7, which drives the debug read-mux address.
REQ-009 The block SHALL have port debug_data, input, 32, the combinational read-mux result for debug_addr.
REQ-010 The block SHALL have port out_valid, output, 1, which marks a captured word as available.
REQ-011 The block SHALL have port out_ready, input, 1, the consumer acceptance signal.
REQ-012 The block SHALL have port out_addr, output, 7, the address of the captured word.
REQ-013 The block SHALL have port out_data, output, 32, the captured word.
REQ-014 The block SHALL have port out_last, output, 1, set with the final word of a scan.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1, a one-clock pulse on normal scan completion.

Function
REQ-017 The FSM SHALL have the states IDLE, SETTLE, SEND and DONE.
REQ-018 In IDLE, start=1 SHALL latch start_addr/end_addr, load debug_addr=start_addr, clear the settle counter and go to SETTLE.
REQ-019 In SETTLE, debug_addr SHALL be held stable; after SETTLE_CYCLES clocks, debug_data SHALL be registered into out_data, debug_addr into out_addr, and the state SHALL go to SEND.
REQ-020 In SEND, out_valid SHALL be 1, and out_addr/out_data/out_last SHALL stay stable until out_valid&out_ready.
REQ-021 When a SEND handshake occurs with out_last=0, debug_addr SHALL increment modulo 128 and the state SHALL go to SETTLE; a handshake with out_last=1 SHALL go to DONE.
REQ-022 DONE SHALL last one clock with done=1 and then go to IDLE.
REQ-023 out_last SHALL be 1 exactly when the captured address equals the latched end_addr.
REQ-024 The scan SHALL transfer ((end_addr - start_addr) mod 128) + 1 words, with address wrap 7'h7F -> 7'h00.
REQ-025 start_addr == end_addr SHALL produce exactly one word.
REQ-026 start SHALL be ignored while busy=1, and the latched range SHALL be unaffected.
REQ-027 abort=1 in SETTLE, SEND or DONE SHALL force IDLE at the next edge, with out_valid=0 and no done pulse; abort has priority over handshake and start.
REQ-028 abort SHALL be ignored in IDLE.
REQ-029 Latency: the first out_valid SHALL rise SETTLE_CYCLES+1 edges after the edge that samples start.
REQ-030 With out_ready held at 1, the spacing between consecutive words SHALL be SETTLE_CYCLES+1 clocks.
REQ-031 debug_addr SHALL hold its last value in IDLE.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, debug_addr=0, out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0, done=0, and clear the settle counter and latched range.
REQ-033 Reset asserted mid-scan SHALL discard the scan; no done pulse or out_valid SHALL follow deassertion.

Verification
REQ-034 start_addr=0x40, end_addr=0x47, ready=1, SETTLE_CYCLES=1 -> 8 words with out_addr 0x40..0x47 and out_data matching the model mux; out_last only on 0x47; one done pulse.
REQ-035 start_addr=0x7E, end_addr=0x01 -> addresses 0x7E, 0x7F, 0x00, 0x01, then done.
REQ-036 start_addr=end_addr=0x20 -> exactly one word with out_last=1; first out_valid 2 clocks after start.
REQ-037 out_ready held at 0 for 5 clocks during word 3 -> out_* stable throughout; debug_addr unchanged; no words lost or duplicated.
REQ-038 abort during SEND of word 2, then rst during SETTLE of a new scan -> out_valid drops next edge, no done pulse, all outputs at reset values.
REQ-039 start pulsed during a scan -> no effect on the range, word count or debug_addr sequence.
